regfile_2w2r_clr: RTL
=====================

Name: regfile_2w2r_clr

Overview:
- Next-generation parametrised register file for the datapath.
- Two independently addressed combinational read ports and two synchronous write ports with defined collision priority.
- Optional hard-wired zero register.
- Multi-cycle hardware clear sequencer with a Busy handshake, so software can wipe architectural state without a full reset.

Parameters:
- W, 8, data path width in bits.
- D, 3, address width; depth is 2**D registers.
- ZERO_REG, 0, when 1: register 0 always reads 0 and ignores writes, including clear.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- WriteEnA  input  1  write enable, port A.
- WaddrA  input  D  write address, port A.
- DataInA  input  W  write data, port A.
- WriteEnB  input  1  write enable, port B.
- WaddrB  input  D  write address, port B.
- DataInB  input  W  write data, port B.
- RaddrA  input  D  read address, port A.
- RaddrB  input  D  read address, port B.
- Clear  input  1  single-cycle request to start the clear sequence.
- Busy  output  1  high while the clear sequence is in progress.
- DataOutA  output  W  read data, port A.
- DataOutB  output  W  read data, port B.

Behaviour:
- Reset (asynchronous, active-high):
  - all 2**D registers go to 0; FSM goes to IDLE; clear counter goes to 0; Busy = 0.
  - DataOutA and DataOutB therefore read 0.
  - Reset asserted mid-clear aborts the sequence immediately, with the same result.
- Reads are combinational: DataOutX = Registers[RaddrX]. Both ports may address the same register.
- Writes are sequential, at posedge:
  - port A writes DataInA to Registers[WaddrA] when WriteEnA;
  - port B likewise for WaddrB/DataInB.
- Collision: if both write enables are high and WaddrA == WaddrB, port B wins and port A's write is dropped.
- Zero register: when ZERO_REG = 1, writes to address 0 are discarded and reads of address 0 return 0 on both ports.
- FSM states: IDLE, CLEAR.
  - IDLE: Clear = 1 at posedge moves to CLEAR and sets the counter to 0. Busy rises in the cycle after Clear is sampled.
  - CLEAR: each posedge writes 0 to Registers[counter], then increments the counter.
  - When a posedge clears the last register (counter = 2**D-1), the FSM returns to IDLE and the counter wraps to 0. Busy is low after that edge.
  - Clear therefore takes exactly 2**D cycles; Busy is high for 2**D cycles.
- While in CLEAR:
  - WriteEnA and WriteEnB are ignored; writes are dropped, not queued.
  - Clear re-asserted is ignored.
  - Reads return current contents: registers already cleared read 0, the rest read old values.
- A write and Clear presented in the same IDLE cycle: the write commits at that edge, then the sequence starts and later overwrites it with 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding, applied only in IDLE and only for enabled, non-discarded writes.
  - If a write targets RaddrX in the current cycle, DataOutX shows the incoming data combinationally.
  - If both write ports match RaddrX, port B data is forwarded, consistent with the collision rule.
  - Forwarding is never applied to address 0 when ZERO_REG = 1.
- Not defined: DataOutX shows the old stored value until the edge after the write; new data is visible the following cycle.

Test Plan:
- Reset, then WriteEnA=1, WaddrA=3, DataInA=8'hA5, one edge; RaddrA=3, RaddrB=3 -> DataOutA = DataOutB = 8'hA5.
- Collision: WaddrA = WaddrB = 5, DataInA=8'h11, DataInB=8'h22, both enables high, one edge -> Registers[5] reads 8'h22.
- Fill all 8 registers with 8'hFF, pulse Clear -> Busy high for exactly 8 cycles. A write of 8'h33 to addr 7 during cycle 2 is dropped. After Busy falls, every address reads 8'h00.
- Assert Reset asynchronously at clear cycle 3 -> Busy drops immediately and all registers read 0. A new Clear after Reset releases runs the full 8 cycles.
- ZERO_REG=1: write 8'h7E to addr 0 -> reads 0. Write 8'h7E to addr 1 -> reads 8'h7E.
- REGFILE_BYPASS_EN defined: WaddrB=2, DataInB=8'h5C, RaddrA=2, same cycle -> DataOutA = 8'h5C before the edge. Macro undefined: DataOutA shows the old value until after the edge.

Source files
------------

// File: rtl/regfile_2w2r_clr.sv
// regfile_2w2r_clr: parametrised 2-write / 2-read register file with a hardware clear sequencer.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2w2r_clr #(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int ZERO_REG = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEnA,
  input  logic [D-1:0] WaddrA,
  input  logic [W-1:0] DataInA,
  input  logic         WriteEnB,
  input  logic [D-1:0] WaddrB,
  input  logic [W-1:0] DataInB,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  input  logic         Clear,
  output logic         Busy,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB
);

  // state | meaning
  // IDLE  | normal operation, both write ports accepted
  // CLEAR | zeroing one register per cycle from address 0 upward; writes dropped
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam int           DEPTH = 1 << D;
  localparam logic [D-1:0] LAST  = {D{1'b1}};

  state_t       state;
  logic [D-1:0] cnt;
  logic [W-1:0] regs [DEPTH];

  logic zero_a, zero_b;
  logic we_a, we_b;

  assign zero_a = (ZERO_REG != 0) && (WaddrA == '0);
  assign zero_b = (ZERO_REG != 0) && (WaddrB == '0);

  // Port B wins a same-address collision, so port A is suppressed outright.
  assign we_b = WriteEnB && !zero_b && (state == IDLE);
  assign we_a = WriteEnA && !zero_a && (state == IDLE)
                && !(WriteEnB && (WaddrB == WaddrA));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (we_a) regs[WaddrA] <= DataInA;
          if (we_b) regs[WaddrB] <= DataInB;
          if (Clear) begin
            state <= CLEAR;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    DataOutA = regs[RaddrA];
`ifdef REGFILE_BYPASS_EN
    if (we_b && (WaddrB == RaddrA))      DataOutA = DataInB;
    else if (we_a && (WaddrA == RaddrA)) DataOutA = DataInA;
`endif
    if ((ZERO_REG != 0) && (RaddrA == '0)) DataOutA = '0;
  end

  always_comb begin
    DataOutB = regs[RaddrB];
`ifdef REGFILE_BYPASS_EN
    if (we_b && (WaddrB == RaddrB))      DataOutB = DataInB;
    else if (we_a && (WaddrA == RaddrB)) DataOutB = DataInA;
`endif
    if ((ZERO_REG != 0) && (RaddrB == '0)) DataOutB = '0;
  end

endmodule
